// File: rtl/reg_bank_wb.sv
// reg_bank_wb: 32-entry write-back register bank with two combinational read
// ports and a sequential dump engine streaming every register over valid/ready.
// Optional build macro: WB_BYPASS_EN enables write-first forwarding on both read
// ports and on dump_data. Without it, a read during a write returns the old value.
// Dump FSM state is observable as {dump_busy, dump_valid, dump_done}:
//   IDLE = 000, SCAN = 110, DONE = 101.
module reg_bank_wb #(
  parameter int               DATA_W   = 32,
  parameter int               SP_INDEX = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr1,
  input  logic [4:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [4:0]        dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  // Handshake: a dump beat transfers on any rising edge where dump_valid and
  // dump_ready are both 1. While dump_valid=1 and dump_ready=0 the beat index
  // is held stable; dump_data tracks the live register contents of that index.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  logic [DATA_W-1:0] regs [32];
  dump_state_t       state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic              wr_live;

  // Writes to index 0 are dropped, so regs[0] is held at zero forever.
  assign wr_live = wr_en && (wr_addr != 5'd0);

  // Register array: reset to zero except the stack pointer; single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports and dump data, optionally forwarding the in-flight write.
  always_comb begin
    rd_data1  = regs[rd_addr1];
    rd_data2  = regs[rd_addr2];
    dump_data = regs[idx_q];
`ifdef WB_BYPASS_EN
    if (wr_live && (wr_addr == rd_addr1)) rd_data1  = wr_data;
    if (wr_live && (wr_addr == rd_addr2)) rd_data2  = wr_data;
    if (wr_live && (wr_addr == idx_q))    dump_data = wr_data;
`endif
  end

  // Dump FSM state and beat index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Dump FSM next-state and outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = SCAN;
          idx_d   = 5'd0;
        end
      end
      SCAN: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          if (idx_q == 5'd31) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      DONE: begin
        dump_done = 1'b1;
        dump_busy = 1'b1;
        state_d   = IDLE;
        idx_d     = 5'd0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 5'd0;
      end
    endcase
  end

  assign dump_idx = idx_q;

endmodule

// File: tb/tb_reg_bank_wb.sv
// tb_reg_bank_wb: directed tests for reg_bank_wb (reset, write/read,
// read-during-write, full dump, backpressure, reset mid-dump, back-to-back).
module tb_reg_bank_wb;

  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [4:0]        rd_addr1;
  logic [4:0]        rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              dump_start;
  logic              dump_ready;
  logic              dump_valid;
  logic [4:0]        dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;

  int checks;
  int errors;

  reg_bank_wb dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one-cycle register write.
  task automatic do_write(input logic [4:0] a, input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_addr1 = 5'd29;
    rd_addr2 = 5'd0;
    #1;
    checks++;
    if (rd_data1 !== 32'd227) begin
      errors++; $display("FAIL reset_sp got=%0d exp=227", rd_data1);
    end
    checks++;
    if (rd_data2 !== 32'd0) begin
      errors++; $display("FAIL reset_r0 got=%0h exp=0", rd_data2);
    end
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd31;
    #1;
    checks++;
    if (rd_data1 !== 32'd0) begin
      errors++; $display("FAIL reset_r5 got=%0h exp=0", rd_data1);
    end
    checks++;
    if (rd_data2 !== 32'd0) begin
      errors++; $display("FAIL reset_r31 got=%0h exp=0", rd_data2);
    end
    checks++;
    if ({dump_valid, dump_busy, dump_done, dump_idx} !== 8'd0) begin
      errors++;
      $display("FAIL reset_dump valid=%b busy=%b done=%b idx=%0d exp all 0",
               dump_valid, dump_busy, dump_done, dump_idx);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd8, 32'hDEADBEEF);
    rd_addr1 = 5'd8;
    #1;
    checks++;
    if (rd_data1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_rd8 got=%h exp=deadbeef", rd_data1);
    end
    do_write(5'd0, 32'h1234);
    rd_addr2 = 5'd0;
    #1;
    checks++;
    if (rd_data2 !== 32'd0) begin
      errors++; $display("FAIL wr_r0 got=%h exp=0", rd_data2);
    end
  endtask

  task automatic test_read_during_write();
    logic [DATA_W-1:0] exp_same;
`ifdef WB_BYPASS_EN
    exp_same = 32'h55;
`else
    exp_same = 32'hDEADBEEF;
`endif
    wr_en    = 1'b1;
    wr_addr  = 5'd8;
    wr_data  = 32'h55;
    rd_addr1 = 5'd8;
    rd_addr2 = 5'd8;
    #1;
    checks++;
    if (rd_data1 !== exp_same) begin
      errors++; $display("FAIL rdw_same1 got=%h exp=%h", rd_data1, exp_same);
    end
    checks++;
    if (rd_data2 !== exp_same) begin
      errors++; $display("FAIL rdw_same2 got=%h exp=%h", rd_data2, exp_same);
    end
    step();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_data1 !== 32'h55) begin
      errors++; $display("FAIL rdw_next got=%h exp=55", rd_data1);
    end
  endtask

  task automatic test_full_dump();
    int busy_cycles;
    busy_cycles = 0;
    for (int k = 1; k < 32; k++) do_write(k[4:0], k * 3);
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int b = 0; b < 32; b++) begin
      if (dump_busy === 1'b1) busy_cycles++;
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== b[4:0] || dump_data !== b * 3) begin
        errors++;
        $display("FAIL dump_beat%0d valid=%b idx=%0d data=%0d exp valid=1 idx=%0d data=%0d",
                 b, dump_valid, dump_idx, dump_data, b, b * 3);
      end
      step();
    end
    if (dump_busy === 1'b1) busy_cycles++;
    checks++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b1) begin
      errors++;
      $display("FAIL dump_done_cycle done=%b valid=%b busy=%b exp 1 0 1",
               dump_done, dump_valid, dump_busy);
    end
    step();
    if (dump_busy === 1'b1) busy_cycles++;
    checks++;
    if (dump_done !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0) begin
      errors++;
      $display("FAIL dump_idle_after done=%b busy=%b idx=%0d exp 0 0 0",
               dump_done, dump_busy, dump_idx);
    end
    checks++;
    if (busy_cycles !== 33) begin
      errors++; $display("FAIL dump_busy_count got=%0d exp=33", busy_cycles);
    end
  endtask

  task automatic test_backpressure();
    bit seen_done;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    dump_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'd4) begin
        errors++;
        $display("FAIL stall_hold%0d valid=%b idx=%0d exp valid=1 idx=4", c, dump_valid, dump_idx);
      end
      if (c == 0) begin
        checks++;
        if (dump_data !== 32'd12) begin
          errors++; $display("FAIL stall_data_old got=%0h exp=c", dump_data);
        end
      end
      if (c == 3) begin
        checks++;
        if (dump_data !== 32'h77) begin
          errors++; $display("FAIL stall_data_new got=%0h exp=77", dump_data);
        end
      end
      if (c == 1) begin
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
      end
      step();
      wr_en = 1'b0;
    end
    dump_ready = 1'b1;
    step();
    checks++;
    if (dump_idx !== 5'd5 || dump_valid !== 1'b1) begin
      errors++; $display("FAIL stall_release idx=%0d valid=%b exp idx=5 valid=1", dump_idx, dump_valid);
    end
    seen_done = 1'b0;
    for (int t = 0; t < 100 && !seen_done; t++) begin
      if (dump_done === 1'b1) seen_done = 1'b1;
      else step();
    end
    checks++;
    if (!seen_done) begin
      errors++; $display("FAIL stall_finish got=no_done exp=done within 100 cycles");
    end
    step();
  endtask

  task automatic test_reset_mid_dump();
    bit done_seen;
    done_seen = 1'b0;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (dump_idx !== 5'd10) begin
      errors++; $display("FAIL mid_reach got=%0d exp=10", dump_idx);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (dump_done === 1'b1) done_seen = 1'b1;
      if (c == 0) begin
        checks++;
        if (dump_valid !== 1'b0 || dump_idx !== 5'd0 || dump_busy !== 1'b0) begin
          errors++;
          $display("FAIL mid_abort valid=%b idx=%0d busy=%b exp 0 0 0", dump_valid, dump_idx, dump_busy);
        end
      end
      step();
    end
    checks++;
    if (done_seen) begin
      errors++; $display("FAIL mid_no_done got=done_pulse exp=none");
    end
    rd_addr1 = 5'd29;
    rd_addr2 = 5'd5;
    #1;
    checks++;
    if (rd_data1 !== 32'd227 || rd_data2 !== 32'd0) begin
      errors++; $display("FAIL mid_regs r29=%0d r5=%0d exp 227 0", rd_data1, rd_data2);
    end
    rd_addr1 = 5'd4;
    rd_addr2 = 5'd31;
    #1;
    checks++;
    if (rd_data1 !== 32'd0 || rd_data2 !== 32'd0) begin
      errors++; $display("FAIL mid_regs2 r4=%0h r31=%0h exp 0 0", rd_data1, rd_data2);
    end
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    checks++;
    if (dump_valid !== 1'b1 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
      errors++;
      $display("FAIL mid_restart valid=%b idx=%0d data=%0h exp 1 0 0", dump_valid, dump_idx, dump_data);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    for (int i = 0; i < 32; i++) step();
    checks++;
    if (dump_done !== 1'b1) begin
      errors++; $display("FAIL b2b_done got=%b exp=1", dump_done);
    end
    step();
    checks++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle valid=%b busy=%b exp 0 0", dump_valid, dump_busy);
    end
    step();
    checks++;
    if (dump_valid !== 1'b1 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
      errors++;
      $display("FAIL b2b_restart valid=%b idx=%0d data=%0h exp 1 0 0", dump_valid, dump_idx, dump_data);
    end
    dump_start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Test sequence
  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = 5'd0;
    wr_data    = '0;
    rd_addr1   = 5'd0;
    rd_addr2   = 5'd0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_read_during_write();
    test_full_dump();
    test_backpressure();
    test_reset_mid_dump();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
